// File: rtl/lfsr_keyed_if.sv
// lfsr_keyed_if: groups the keying/stepping controls and the register view
// of one lfsr_keyed instance. WIDTH must match the attached lfsr_keyed.
// Optional signal zero_flag exists only when LFSR_ZERO_DETECT_EN is defined.
interface lfsr_keyed_if #(
    parameter int WIDTH = 22
);
    logic               load_start;
    logic               din_valid;
    logic               din;
    logic               din_ready;
    logic               par_load;
    logic [0:WIDTH-1]   par_data;
    logic               step;
    logic [0:WIDTH-1]   state;
    logic               out_bit;
    logic               busy;
    logic               load_done;
    logic [7:0]         bit_cnt;
`ifdef LFSR_ZERO_DETECT_EN
    logic               zero_flag;
`endif

    // Controller side: drives requests, observes the register.
    modport master (
        output load_start, din_valid, din, par_load, par_data, step,
`ifdef LFSR_ZERO_DETECT_EN
        input  zero_flag,
`endif
        input  din_ready, state, out_bit, busy, load_done, bit_cnt
    );

    // Register side.
    modport slave (
        input  load_start, din_valid, din, par_load, par_data, step,
`ifdef LFSR_ZERO_DETECT_EN
        output zero_flag,
`endif
        output din_ready, state, out_bit, busy, load_done, bit_cnt
    );
endinterface

// File: rtl/lfsr_keyed.sv
// lfsr_keyed: parametrised Fibonacci LFSR with a serial keying sequencer
// (clear, then XOR-inject LOAD_LEN bits), parallel preload and gated stepping.
// State is indexed [0:WIDTH-1]; bit 0 receives the new bit, bit WIDTH-1 is
// the output bit. Optional macro LFSR_ZERO_DETECT_EN adds a registered
// all-zero indicator (zero_flag) that is only asserted while idle.
module lfsr_keyed #(
    parameter int               WIDTH         = 22,
    parameter logic [0:WIDTH-1] TAPS          = 22'h000003,
    parameter int               LOAD_LEN      = 86,
    parameter bit               CLEAR_ON_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    lfsr_keyed_if.slave bus
);
    localparam logic [7:0] LAST_CNT = 8'(LOAD_LEN - 1);

    typedef enum logic {IDLE, LOAD} fsm_t;

    fsm_t               fsm_reg, fsm_next;
    logic [0:WIDTH-1]   state_reg, state_next;
    logic [7:0]         bit_cnt_reg, bit_cnt_next;
    logic               load_done_reg, load_done_next;

    logic [0:WIDTH-1]   tap_hits;
    logic               fb;
    logic [0:WIDTH-1]   step_val;
    logic [0:WIDTH-1]   load_val;

    // Per-bit tap products; feedback is their parity.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_hits[gi] = state_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign fb       = ^tap_hits;
    assign step_val = {fb, state_reg[0:WIDTH-2]};
    assign load_val = {fb ^ bus.din, state_reg[0:WIDTH-2]};

    // Next-state logic: IDLE gives par_load > load_start > step priority;
    // LOAD only reacts to accepted serial bits.
    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        load_done_next = 1'b0;
        unique case (fsm_reg)
            IDLE: begin
                if (bus.par_load) begin
                    state_next = bus.par_data;
                end else if (bus.load_start) begin
                    fsm_next     = LOAD;
                    bit_cnt_next = '0;
                    if (CLEAR_ON_LOAD) begin
                        state_next = '0;
                    end
                end else if (bus.step) begin
                    state_next = step_val;
                end
            end
            LOAD: begin
                if (bus.din_valid) begin
                    state_next   = load_val;
                    bit_cnt_next = bit_cnt_reg + 8'd1;
                    if (bit_cnt_reg == LAST_CNT) begin
                        fsm_next       = IDLE;
                        load_done_next = 1'b1;
                    end
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any sequence in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            bit_cnt_reg   <= '0;
            load_done_reg <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            load_done_reg <= load_done_next;
        end
    end

`ifdef LFSR_ZERO_DETECT_EN
    logic zero_flag_reg, zero_flag_next;

    assign zero_flag_next = (fsm_next == IDLE) && (state_next == '0);

    // Zero indicator tracks the register after each edge, suppressed in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag_reg <= 1'b0;
        end else begin
            zero_flag_reg <= zero_flag_next;
        end
    end

    assign bus.zero_flag = zero_flag_reg;
`endif

    assign bus.state     = state_reg;
    assign bus.out_bit   = state_reg[WIDTH-1];
    assign bus.busy      = (fsm_reg == LOAD);
    assign bus.din_ready = (fsm_reg == LOAD);
    assign bus.load_done = load_done_reg;
    assign bus.bit_cnt   = bit_cnt_reg;
endmodule

// File: tb/tb_lfsr_keyed.sv
// tb_lfsr_keyed: table-driven vectors, hand sequences for the multi-cycle
// keying cases and a randomized run against a bit-array reference model.
module tb_lfsr_keyed;
    localparam int W   = 22;
    localparam int LEN = 86;

    logic clk;
    logic reset;

    lfsr_keyed_if #(.WIDTH(W)) bus ();

    lfsr_keyed #(
        .WIDTH(W), .TAPS(22'h000003), .LOAD_LEN(LEN), .CLEAR_ON_LOAD(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: register as an array of bits, taps as index list.
    bit m_st[W];
    int m_cnt;
    bit m_loading;
    bit m_done;
    bit m_zero;
    int tap_idx[2] = '{20, 21};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [0:W-1] model_vec();
        logic [0:W-1] v;
        for (int i = 0; i < W; i++) v[i] = m_st[i];
        return v;
    endfunction

    task automatic model_shift(input bit inj);
        int ones = 0;
        bit nb;
        foreach (tap_idx[k]) if (m_st[tap_idx[k]]) ones++;
        nb = bit'(ones % 2) ^ inj;
        for (int i = W - 1; i > 0; i--) m_st[i] = m_st[i-1];
        m_st[0] = nb;
    endtask

    task automatic model_edge();
        int nz = 0;
        if (reset) begin
            for (int i = 0; i < W; i++) m_st[i] = 1'b0;
            m_cnt = 0; m_loading = 1'b0; m_done = 1'b0; m_zero = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_loading) begin
                if (bus.par_load) begin
                    for (int i = 0; i < W; i++) m_st[i] = bus.par_data[i];
                end else if (bus.load_start) begin
                    m_loading = 1'b1;
                    m_cnt = 0;
                    for (int i = 0; i < W; i++) m_st[i] = 1'b0;
                end else if (bus.step) begin
                    model_shift(1'b0);
                end
            end else if (bus.din_valid) begin
                model_shift(bus.din);
                m_cnt++;
                if (m_cnt == LEN) begin
                    m_loading = 1'b0;
                    m_done = 1'b1;
                end
            end
            for (int i = 0; i < W; i++) nz += int'(m_st[i]);
            m_zero = !m_loading && (nz == 0);
        end
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.load_start = 1'b0; bus.din_valid = 1'b0; bus.din = 1'b0;
        bus.par_load = 1'b0; bus.par_data = '0; bus.step = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 64'(bus.state), 64'(model_vec()));
        check({tag, ".out_bit"}, 64'(bus.out_bit), 64'(m_st[W-1]));
        check({tag, ".busy"}, 64'(bus.busy), 64'(m_loading));
        check({tag, ".din_ready"}, 64'(bus.din_ready), 64'(m_loading));
        check({tag, ".load_done"}, 64'(bus.load_done), 64'(m_done));
        check({tag, ".bit_cnt"}, 64'(bus.bit_cnt), 64'(m_cnt));
`ifdef LFSR_ZERO_DETECT_EN
        check({tag, ".zero_flag"}, 64'(bus.zero_flag), 64'(m_zero));
`endif
    endtask

    typedef struct {
        logic         par_load;
        logic [0:W-1] par_data;
        logic         load_start;
        logic         step;
        logic         din_valid;
        logic         din;
        logic [0:W-1] exp_state;
        logic         exp_busy;
        logic [7:0]   exp_cnt;
        logic         exp_done;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [0:W-1] prev;
        int pulses;
        bit got_done;

        // {par_load, par_data, load_start, step, din_valid, din, state, busy, cnt, done}
        vecs[0]  = '{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 22'h3FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 22'h3FFFFF, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 22'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 22'h1FFFFF, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 22'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0FFFFF, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0FFFFF, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 22'h0ABCDE, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0ABCDE, 1'b0, 8'd0, 1'b0};
        // taps: state[20]=1, state[21]=0 -> feedback 1 enters bit 0
        vecs[6]  = '{1'b0, 22'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 22'h255E6F, 1'b0, 8'd0, 1'b0};
        vecs[7]  = '{1'b1, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000, 1'b0, 8'd0, 1'b0};
        vecs[8]  = '{1'b0, 22'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 22'h000000, 1'b0, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000000, 1'b1, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 22'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 22'h000000, 1'b1, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 22'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 22'h200000, 1'b1, 8'd1, 1'b0};
        vecs[12] = '{1'b1, 22'h3FFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 22'h200000, 1'b1, 8'd1, 1'b0};

        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("rst.state", 64'(bus.state), 64'h0);
        check("rst.out_bit", 64'(bus.out_bit), 64'h0);
        check("rst.busy", 64'(bus.busy), 64'h0);
        check("rst.load_done", 64'(bus.load_done), 64'h0);
        check("rst.bit_cnt", 64'(bus.bit_cnt), 64'h0);

        // Table vectors: one cycle each, checked after the edge.
        foreach (vecs[i]) begin
            bus.par_load = vecs[i].par_load; bus.par_data = vecs[i].par_data;
            bus.load_start = vecs[i].load_start; bus.step = vecs[i].step;
            bus.din_valid = vecs[i].din_valid; bus.din = vecs[i].din;
            tick();
            check($sformatf("vec%0d.state", i), 64'(bus.state), 64'(vecs[i].exp_state));
            check($sformatf("vec%0d.out_bit", i), 64'(bus.out_bit), 64'(vecs[i].exp_state[W-1]));
            check($sformatf("vec%0d.busy", i), 64'(bus.busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d.bit_cnt", i), 64'(bus.bit_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d.load_done", i), 64'(bus.load_done), 64'(vecs[i].exp_done));
            $display("vec %0d state=%06h busy=%0d cnt=%0d", i, bus.state, bus.busy, bus.bit_cnt);
        end

        // Single 1 followed by zeros: tap 20 fires on bit 22, so the 1 is
        // re-injected while the original still sits in bit 21.
        do_reset();
        bus.load_start = 1'b1; tick(); idle_inputs();
        bus.din_valid = 1'b1; bus.din = 1'b1; tick();
        bus.din = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        check("seqA.state22", 64'(bus.state), 64'h200001);
        check("seqA.cnt22", 64'(bus.bit_cnt), 64'd22);
        tick();
        check("seqA.state23", 64'(bus.state), 64'h300000);
        check("seqA.cnt23", 64'(bus.bit_cnt), 64'd23);
        $display("seqA state=%06h cnt=%0d", bus.state, bus.bit_cnt);

        // Full load with a 3-cycle stall and step pulses throughout.
        do_reset();
        pulses = 0;
        bus.load_start = 1'b1; tick(); idle_inputs();
        compare_all("seqB.start");
        for (int b = 0; b < LEN; b++) begin
            if (b == 30) begin
                for (int g = 0; g < 3; g++) begin
                    bus.din_valid = 1'b0; bus.step = 1'b1;
                    prev = bus.state;
                    tick();
                    check("seqB.gap_frozen", 64'(bus.state), 64'(prev));
                    check("seqB.gap_cnt", 64'(bus.bit_cnt), 64'd30);
                end
            end
            bus.din_valid = 1'b1; bus.din = 1'($urandom); bus.step = 1'($urandom);
            tick();
            if (bus.load_done) pulses++;
            compare_all("seqB.bit");
        end
        idle_inputs();
        check("seqB.done_after_last", 64'(bus.load_done), 64'h1);
        check("seqB.busy_fall", 64'(bus.busy), 64'h0);
        check("seqB.cnt_final", 64'(bus.bit_cnt), 64'(LEN));
        tick();
        if (bus.load_done) pulses++;
        check("seqB.done_pulses", 64'(pulses), 64'd1);
        check("seqB.cnt_hold", 64'(bus.bit_cnt), 64'(LEN));
        $display("seqB state=%06h pulses=%0d", bus.state, pulses);

        // Reset at bit 40, then a clean reload.
        do_reset();
        bus.load_start = 1'b1; tick(); idle_inputs();
        bus.din_valid = 1'b1;
        for (int b = 0; b < 40; b++) begin bus.din = 1'($urandom); tick(); end
        check("seqC.cnt40", 64'(bus.bit_cnt), 64'd40);
        reset = 1'b1; tick(); reset = 1'b0; idle_inputs();
        check("seqC.rst_state", 64'(bus.state), 64'h0);
        check("seqC.rst_busy", 64'(bus.busy), 64'h0);
        check("seqC.rst_cnt", 64'(bus.bit_cnt), 64'h0);
        check("seqC.rst_done", 64'(bus.load_done), 64'h0);
        tick();
        check("seqC.no_done", 64'(bus.load_done), 64'h0);
        bus.load_start = 1'b1; tick(); idle_inputs();
        got_done = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            bus.din_valid = 1'($urandom); bus.din = 1'($urandom);
            tick();
            compare_all("seqC.reload");
            got_done = bus.load_done;
        end
        idle_inputs();
        check("seqC.done_seen", 64'(got_done), 64'h1);
        $display("seqC state=%06h done=%0d", bus.state, got_done);

`ifdef LFSR_ZERO_DETECT_EN
        bus.par_load = 1'b1; bus.par_data = 22'h000000; tick();
        check("zero.set", 64'(bus.zero_flag), 64'h1);
        bus.par_data = 22'h000001; tick();
        check("zero.clear", 64'(bus.zero_flag), 64'h0);
        idle_inputs();
        $display("zero_flag sequence done");
`endif

        // Randomized mixed traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.par_load   = ($urandom_range(0, 15) == 0);
            bus.par_data   = 22'($urandom);
            bus.load_start = ($urandom_range(0, 7) == 0);
            bus.step       = 1'($urandom);
            bus.din_valid  = ($urandom_range(0, 3) != 0);
            bus.din        = 1'($urandom);
            tick();
            compare_all("rand");
        end
        reset = 1'b0;
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
